// File: rtl/bank_rdata_return_pkg.sv
// xmem bank return path: shared types, bank counts and tag encoder.
// Used by both the address-side decode and the read-data return path.
package bank_rdata_return_pkg;

  typedef enum logic [1:0] {
    MEM_TYPE_SCALAR = 2'd0,
    MEM_TYPE_ARRAY  = 2'd1,
    MEM_TYPE_CYCLIC = 2'd2
  } mem_type_e;

  // Entry n is the bank count of memory type n.
  localparam logic [2:0][7:0] BANK_NUM = {8'd4, 8'd4, 8'd2};

  localparam int BANK_RD_LAT = 2;

  function automatic int max3(input int a, input int b, input int c);
    int m;
    m = (a > b) ? a : b;
    return (m > c) ? m : c;
  endfunction

  localparam int MAX_BANKS = max3(int'(BANK_NUM[0]),
                                  int'(BANK_NUM[1]),
                                  int'(BANK_NUM[2]));
  localparam int BANK_IDX_W =
    (MAX_BANKS > 1) ? $clog2(MAX_BANKS) : 1;

  // Each type owns a power-of-two slot of the match vector,
  // so the flat one-hot index splits into {type, bank}.
  localparam int SLOT_W    = 1 << BANK_IDX_W;
  localparam int ENC_W     = 3 * SLOT_W;
  localparam int ENC_IDX_W = 2 + BANK_IDX_W;

  typedef struct packed {
    mem_type_e               mem_type;
    logic [BANK_IDX_W-1:0]   bank_idx;
  } bank_tag_t;

  // Returns {idx, err}; err is set unless exactly one bit is set.
  function automatic logic [ENC_IDX_W:0] onehot_enc(
    input logic [ENC_W-1:0] v
  );
    logic [ENC_IDX_W-1:0] idx;
    int                   cnt;
    idx = '0;
    cnt = 0;
    for (int i = 0; i < ENC_W; i++) begin
      if (v[i]) begin
        idx = ENC_IDX_W'(i);
        cnt++;
      end
    end
    return {idx, (cnt != 1)};
  endfunction

endpackage

// File: rtl/bank_rsp_fifo.sv
// Response FIFO for the bank return path.
// Head is read straight from the storage registers.
module bank_rsp_fifo #(
  parameter int WIDTH = 33,
  parameter int DEPTH = 4
) (
  input  logic             clk,
  input  logic             rstn,
  input  logic             push,
  input  logic             pop,
  input  logic [WIDTH-1:0] din,
  output logic             full,
  output logic             empty,
  output logic [WIDTH-1:0] head
);

  localparam int AW = $clog2(DEPTH);

  logic [WIDTH-1:0] r_mem [DEPTH];
  logic [AW-1:0]    r_wp;
  logic [AW-1:0]    r_rp;
  logic [AW:0]      r_cnt;
  logic             w_do_pop;
  logic             w_do_push;

  assign full      = (r_cnt == (AW+1)'(DEPTH));
  assign empty     = (r_cnt == '0);
  assign head      = r_mem[r_rp];
  assign w_do_pop  = pop & ~empty;
  assign w_do_push = push & (~full | w_do_pop);

  // Storage, wrap-around pointers and occupancy.
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      for (int i = 0; i < DEPTH; i++) r_mem[i] <= '0;
      r_wp  <= '0;
      r_rp  <= '0;
      r_cnt <= '0;
    end else begin
      if (w_do_push) begin
        r_mem[r_wp] <= din;
        r_wp        <= r_wp + AW'(1);
      end
      if (w_do_pop) r_rp <= r_rp + AW'(1);
      unique case ({w_do_push, w_do_pop})
        2'b10:   r_cnt <= r_cnt + (AW+1)'(1);
        2'b01:   r_cnt <= r_cnt - (AW+1)'(1);
        default: r_cnt <= r_cnt;
      endcase
    end
  end

  a_no_overflow: assert property (
    @(posedge clk) disable iff (!rstn)
    push |-> (!full || pop));

endmodule

// File: rtl/bank_rdata_return.sv
// xmem bank fabric read-data return path.
// Tags reads, tracks bank latency, returns data in order.
module bank_rdata_return
  import bank_rdata_return_pkg::*;
#(
  parameter int DATA_W     = 32,
  parameter int RD_LAT     = BANK_RD_LAT,
  parameter int FIFO_DEPTH = 4,
  parameter int N_SCALAR   = int'(BANK_NUM[MEM_TYPE_SCALAR]),
  parameter int N_ARRAY    = int'(BANK_NUM[MEM_TYPE_ARRAY]),
  parameter int N_CYCLIC   = int'(BANK_NUM[MEM_TYPE_CYCLIC])
) (
  input  logic                             clk,
  input  logic                             rstn,
  input  logic                             req_valid,
  input  logic                             req_we,
  output logic                             req_ready,
  input  logic [N_SCALAR-1:0]              matched_scalar,
  input  logic [N_ARRAY-1:0]               matched_array,
  input  logic [N_CYCLIC-1:0]              matched_cyclic,
  input  logic [N_SCALAR-1:0][DATA_W-1:0]  rdata_scalar,
  input  logic [N_ARRAY-1:0][DATA_W-1:0]   rdata_array,
  input  logic [N_CYCLIC-1:0][DATA_W-1:0]  rdata_cyclic,
  output logic                             rsp_valid,
  input  logic                             rsp_ready,
  output logic [DATA_W-1:0]                rsp_data,
  output logic                             rsp_err,
  output logic [$clog2(FIFO_DEPTH):0]      outstanding
);

  localparam int CNT_W = $clog2(FIFO_DEPTH) + 1;
  localparam int FW    = DATA_W + 1;

  if (RD_LAT < 1) begin : g_bad_lat
    $error("RD_LAT must be at least 1");
  end
  if (FIFO_DEPTH < 2 || (FIFO_DEPTH & (FIFO_DEPTH - 1)) != 0)
  begin : g_bad_depth
    $error("FIFO_DEPTH must be a power of two >= 2");
  end
  if (N_SCALAR > SLOT_W || N_ARRAY > SLOT_W || N_CYCLIC > SLOT_W)
  begin : g_bad_banks
    $error("bank count exceeds package tag width");
  end

  logic                  w_rd_fire;
  logic                  w_pop;
  logic                  w_push;
  logic                  w_full;
  logic                  w_empty;
  logic [SLOT_W-1:0]     w_pad_s;
  logic [SLOT_W-1:0]     w_pad_a;
  logic [SLOT_W-1:0]     w_pad_c;
  logic [ENC_IDX_W:0]    w_enc;
  bank_tag_t             w_tag;
  logic                  w_err;
  bank_tag_t             w_ltag;
  logic                  w_lerr;
  logic [DATA_W-1:0]     w_word;
  logic [FW-1:0]         w_head;
  logic                  w_idx_ok;
  logic [CNT_W-1:0]      r_out;
  logic                  r_vld [RD_LAT];
  bank_tag_t             r_tag [RD_LAT];
  logic                  r_err [RD_LAT];

  assign req_ready   = (r_out < CNT_W'(FIFO_DEPTH));
  assign w_rd_fire   = req_valid & req_ready & ~req_we;
  assign rsp_valid   = ~w_empty;
  assign w_pop       = rsp_valid & rsp_ready;
  assign outstanding = r_out;
  assign rsp_data    = w_head[DATA_W-1:0];
  assign rsp_err     = w_head[DATA_W];

  assign w_pad_s = SLOT_W'(matched_scalar);
  assign w_pad_a = SLOT_W'(matched_array);
  assign w_pad_c = SLOT_W'(matched_cyclic);
  assign w_enc   = onehot_enc({w_pad_c, w_pad_a, w_pad_s});

  // Split the flat one-hot index into {mem_type, bank_idx}.
  always_comb begin
    w_err          = w_enc[0];
    w_tag.mem_type = mem_type_e'(w_enc[ENC_IDX_W -: 2]);
    w_tag.bank_idx = w_enc[BANK_IDX_W:1];
  end

  // Tag pipeline tracking the fixed bank latency; never stalls.
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      for (int s = 0; s < RD_LAT; s++) begin
        r_vld[s] <= 1'b0;
        r_tag[s] <= '0;
        r_err[s] <= 1'b0;
      end
    end else begin
      r_vld[0] <= w_rd_fire;
      r_tag[0] <= w_tag;
      r_err[0] <= w_err;
      for (int s = 1; s < RD_LAT; s++) begin
        r_vld[s] <= r_vld[s-1];
        r_tag[s] <= r_tag[s-1];
        r_err[s] <= r_err[s-1];
      end
    end
  end

  assign w_ltag = r_tag[RD_LAT-1];
  assign w_lerr = r_err[RD_LAT-1];
  assign w_push = r_vld[RD_LAT-1];

  // Pick the addressed bank's data; bad tags return zero.
  always_comb begin
    w_word = '0;
    if (!w_lerr) begin
      unique case (w_ltag.mem_type)
        MEM_TYPE_SCALAR:
          for (int b = 0; b < N_SCALAR; b++)
            if (int'(w_ltag.bank_idx) == b)
              w_word = rdata_scalar[b];
        MEM_TYPE_ARRAY:
          for (int b = 0; b < N_ARRAY; b++)
            if (int'(w_ltag.bank_idx) == b)
              w_word = rdata_array[b];
        MEM_TYPE_CYCLIC:
          for (int b = 0; b < N_CYCLIC; b++)
            if (int'(w_ltag.bank_idx) == b)
              w_word = rdata_cyclic[b];
        default: w_word = '0;
      endcase
    end
  end

  // Credit count: reads in the tag pipe plus entries queued.
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      r_out <= '0;
    end else if (w_rd_fire && !w_pop) begin
      r_out <= r_out + CNT_W'(1);
    end else if (!w_rd_fire && w_pop) begin
      r_out <= r_out - CNT_W'(1);
    end
  end

  bank_rsp_fifo #(
    .WIDTH (FW),
    .DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .clk   (clk),
    .rstn  (rstn),
    .push  (w_push),
    .pop   (w_pop),
    .din   ({w_lerr, w_word}),
    .full  (w_full),
    .empty (w_empty),
    .head  (w_head)
  );

  // Bank index must lie inside its type's bank count.
  always_comb begin
    w_idx_ok = 1'b0;
    unique case (w_ltag.mem_type)
      MEM_TYPE_SCALAR: w_idx_ok = int'(w_ltag.bank_idx) < N_SCALAR;
      MEM_TYPE_ARRAY:  w_idx_ok = int'(w_ltag.bank_idx) < N_ARRAY;
      MEM_TYPE_CYCLIC: w_idx_ok = int'(w_ltag.bank_idx) < N_CYCLIC;
      default:         w_idx_ok = 1'b0;
    endcase
  end

  a_out_range: assert property (
    @(posedge clk) disable iff (!rstn)
    r_out <= CNT_W'(FIFO_DEPTH));

  a_idx_range: assert property (
    @(posedge clk) disable iff (!rstn)
    (w_push && !w_lerr) |-> w_idx_ok);

  a_push_room: assert property (
    @(posedge clk) disable iff (!rstn)
    w_push |-> (!w_full || w_pop));

endmodule

// File: tb/tb_bank_rdata_return.sv
// Bench for bank_rdata_return: vector table, directed
// sequences and random traffic against a queue-based model.
module tb_bank_rdata_return;

  localparam int DW    = 32;
  localparam int LAT   = 2;
  localparam int DEPTH = 4;
  localparam int NS    = 2;
  localparam int NA    = 4;
  localparam int NC    = 4;
  localparam int OW    = 3;

  logic                  clk = 1'b0;
  logic                  rstn = 1'b0;
  logic                  req_valid = 1'b0;
  logic                  req_we = 1'b0;
  logic                  req_ready;
  logic [NS-1:0]         ms = '0;
  logic [NA-1:0]         ma = '0;
  logic [NC-1:0]         mc = '0;
  logic [NS-1:0][DW-1:0] rd_s;
  logic [NA-1:0][DW-1:0] rd_a;
  logic [NC-1:0][DW-1:0] rd_c;
  logic                  rsp_valid;
  logic                  rsp_ready = 1'b0;
  logic [DW-1:0]         rsp_data;
  logic                  rsp_err;
  logic [OW-1:0]         outstanding;

  always #5 clk = ~clk;

  bank_rdata_return #(
    .DATA_W     (DW),
    .RD_LAT     (LAT),
    .FIFO_DEPTH (DEPTH),
    .N_SCALAR   (NS),
    .N_ARRAY    (NA),
    .N_CYCLIC   (NC)
  ) dut (
    .clk            (clk),
    .rstn           (rstn),
    .req_valid      (req_valid),
    .req_we         (req_we),
    .req_ready      (req_ready),
    .matched_scalar (ms),
    .matched_array  (ma),
    .matched_cyclic (mc),
    .rdata_scalar   (rd_s),
    .rdata_array    (rd_a),
    .rdata_cyclic   (rd_c),
    .rsp_valid      (rsp_valid),
    .rsp_ready      (rsp_ready),
    .rsp_data       (rsp_data),
    .rsp_err        (rsp_err),
    .outstanding    (outstanding)
  );

  int n_vec = 0;
  int n_err = 0;
  int k = 0;

  task automatic chk(input string nm, input logic [31:0] act,
                     input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s @cyc %0d: got %h, want %h", nm, k, act, exp);
    end
  endtask

  // Reference model: reads in flight keyed by the cycle their
  // bank data is valid, and the queue of visible responses.
  typedef struct {
    int            p;
    logic [NS-1:0] s;
    logic [NA-1:0] a;
    logic [NC-1:0] c;
  } fl_t;
  typedef struct {
    logic [DW-1:0] d;
    logic          e;
  } rs_t;

  fl_t fl[$];
  rs_t mq[$];

  function automatic rs_t resolve(input fl_t f);
    rs_t r;
    r.d = '0;
    r.e = 1'b1;
    if ($countones({f.c, f.a, f.s}) == 1) begin
      r.e = 1'b0;
      for (int i = 0; i < NS; i++) if (f.s[i]) r.d = rd_s[i];
      for (int i = 0; i < NA; i++) if (f.a[i]) r.d = rd_a[i];
      for (int i = 0; i < NC; i++) if (f.c[i]) r.d = rd_c[i];
    end
    return r;
  endfunction

  // Compare this cycle against the model, advance both by a clock.
  task automatic tick();
    int   eo;
    logic er;
    logic fire;
    logic pop;
    rs_t  r;
    fl_t  f;
    eo = mq.size() + fl.size();
    er = (eo < DEPTH);
    chk("m_rsp_valid", 32'(rsp_valid), 32'(mq.size() > 0));
    if (mq.size() > 0) begin
      chk("m_rsp_data", rsp_data, mq[0].d);
      chk("m_rsp_err", 32'(rsp_err), 32'(mq[0].e));
    end
    chk("m_outstanding", 32'(outstanding), 32'(eo));
    chk("m_req_ready", 32'(req_ready), 32'(er));
    fire = req_valid & er & ~req_we;
    pop  = (mq.size() > 0) && rsp_ready;
    if (pop) void'(mq.pop_front());
    if (fl.size() > 0 && fl[0].p == k) begin
      r = resolve(fl[0]);
      mq.push_back(r);
      void'(fl.pop_front());
    end
    if (fire) begin
      f.p = k + LAT;
      f.s = ms;
      f.a = ma;
      f.c = mc;
      fl.push_back(f);
    end
    @(posedge clk);
    #1;
    k++;
  endtask

  task automatic set_m(input int ty, input int idx);
    ms = '0;
    ma = '0;
    mc = '0;
    case (ty)
      0: ms[idx] = 1'b1;
      1: ma[idx] = 1'b1;
      2: mc[idx] = 1'b1;
      default: ;
    endcase
  endtask

  task automatic rd(input int ty, input int idx);
    req_valid = 1'b1;
    req_we    = 1'b0;
    set_m(ty, idx);
  endtask

  task automatic idle();
    req_valid = 1'b0;
    req_we    = 1'b0;
    set_m(3, 0);
  endtask

  task automatic load_banks();
    for (int i = 0; i < NS; i++) rd_s[i] = 32'h100 + 32'(i);
    for (int i = 0; i < NA; i++) rd_a[i] = 32'h200 + 32'(i);
    for (int i = 0; i < NC; i++) rd_c[i] = 32'h100 + 32'(i);
    rd_a[2] = 32'hDEADBEEF;
  endtask

  typedef struct {
    logic          we;
    logic [NS-1:0] s;
    logic [NA-1:0] a;
    logic [NC-1:0] c;
    logic          v;
    logic [DW-1:0] d;
    logic          e;
  } vec_t;

  vec_t tbl[12];

  initial begin
    tbl[0]  = '{1'b0, 2'b00, 4'b0100, 4'b0000, 1'b1, 32'hDEADBEEF, 1'b0};
    tbl[1]  = '{1'b0, 2'b01, 4'b0000, 4'b0000, 1'b1, 32'h100, 1'b0};
    tbl[2]  = '{1'b0, 2'b10, 4'b0000, 4'b0000, 1'b1, 32'h101, 1'b0};
    tbl[3]  = '{1'b0, 2'b00, 4'b0000, 4'b1000, 1'b1, 32'h103, 1'b0};
    tbl[4]  = '{1'b0, 2'b00, 4'b0000, 4'b0100, 1'b1, 32'h102, 1'b0};
    tbl[5]  = '{1'b0, 2'b00, 4'b0001, 4'b0000, 1'b1, 32'h200, 1'b0};
    tbl[6]  = '{1'b0, 2'b00, 4'b1000, 4'b0000, 1'b1, 32'h203, 1'b0};
    tbl[7]  = '{1'b0, 2'b11, 4'b0000, 4'b0000, 1'b1, 32'h0, 1'b1};
    tbl[8]  = '{1'b0, 2'b00, 4'b0000, 4'b0000, 1'b1, 32'h0, 1'b1};
    tbl[9]  = '{1'b0, 2'b01, 4'b0001, 4'b0000, 1'b1, 32'h0, 1'b1};
    tbl[10] = '{1'b1, 2'b00, 4'b0100, 4'b0000, 1'b0, 32'h0, 1'b0};
    tbl[11] = '{1'b0, 2'b00, 4'b0010, 4'b0000, 1'b1, 32'h201, 1'b0};

    load_banks();

    // Reset state.
    @(posedge clk);
    #1;
    chk("rst_rsp_valid", 32'(rsp_valid), 32'd0);
    chk("rst_outstanding", 32'(outstanding), 32'd0);
    chk("rst_req_ready", 32'(req_ready), 32'd1);
    chk("rst_rsp_data", rsp_data, 32'd0);
    chk("rst_rsp_err", 32'(rsp_err), 32'd0);
    #2 rstn = 1'b1;
    @(posedge clk);
    #1;

    // Vector table: one access into an empty FIFO, exact latency.
    rsp_ready = 1'b1;
    for (int v = 0; v < 12; v++) begin
      req_valid = 1'b1;
      req_we    = tbl[v].we;
      ms        = tbl[v].s;
      ma        = tbl[v].a;
      mc        = tbl[v].c;
      tick();
      idle();
      tick();
      chk($sformatf("tbl%0d_early", v), 32'(rsp_valid), 32'd0);
      tick();
      chk($sformatf("tbl%0d_valid", v), 32'(rsp_valid), 32'(tbl[v].v));
      if (tbl[v].v) begin
        chk($sformatf("tbl%0d_data", v), rsp_data, tbl[v].d);
        chk($sformatf("tbl%0d_err", v), 32'(rsp_err), 32'(tbl[v].e));
      end
      tick();
      tick();
    end

    // Streaming: 8 back-to-back reads, no bubbles.
    rsp_ready = 1'b1;
    for (int t = 0; t < 12; t++) begin
      if (t < 8) begin
        if (t % 2 == 0) rd(0, 0);
        else rd(2, 3);
        chk("stream_ready", 32'(req_ready), 32'd1);
      end else begin
        idle();
      end
      if (t >= 3 && t < 11) begin
        chk("stream_valid", 32'(rsp_valid), 32'd1);
        chk("stream_data", rsp_data,
            ((t - 3) % 2 == 0) ? 32'h100 : 32'h103);
      end
      tick();
    end

    // Backpressure: credit stops accepts at FIFO_DEPTH.
    rsp_ready = 1'b0;
    for (int t = 0; t < 6; t++) begin
      case (t)
        0: rd(0, 0);
        1: rd(1, 0);
        2: rd(2, 2);
        3: rd(1, 3);
        4: rd(0, 1);
        default: rd(2, 3);
      endcase
      chk("bp_ready", 32'(req_ready), 32'(t < 4));
      tick();
    end
    idle();
    chk("bp_outstanding", 32'(outstanding), 32'd4);
    chk("bp_ready_low", 32'(req_ready), 32'd0);
    chk("bp_head0", rsp_data, 32'h100);
    rsp_ready = 1'b1;
    tick();
    rsp_ready = 1'b0;
    chk("bp_ready_back", 32'(req_ready), 32'd1);
    chk("bp_out3", 32'(outstanding), 32'd3);
    chk("bp_head1", rsp_data, 32'h200);
    rd(1, 2);
    tick();
    idle();
    chk("bp_out4", 32'(outstanding), 32'd4);
    tick();
    rsp_ready = 1'b1;
    tick();
    rsp_ready = 1'b0;
    chk("pp_out", 32'(outstanding), 32'd3);
    chk("pp_head", rsp_data, 32'h102);
    rsp_ready = 1'b1;
    for (int t = 0; t < 5; t++) tick();
    chk("bp_drained", 32'(outstanding), 32'd0);

    // Writes interleaved with reads.
    req_valid = 1'b1;
    req_we    = 1'b1;
    set_m(0, 0);
    tick();
    chk("wr_no_count", 32'(outstanding), 32'd0);
    rd(1, 0);
    tick();
    req_we = 1'b1;
    set_m(1, 2);
    tick();
    chk("wr_mix_out", 32'(outstanding), 32'd1);
    rd(2, 2);
    tick();
    idle();
    chk("wr_mix_out2", 32'(outstanding), 32'd2);
    chk("wr_mix_data", rsp_data, 32'h200);
    for (int t = 0; t < 5; t++) tick();

    // Random traffic, bank data changing every cycle.
    for (int t = 0; t < 500; t++) begin
      int r;
      req_valid = ($urandom_range(0, 9) < 7);
      req_we    = ($urandom_range(0, 3) == 0);
      rsp_ready = ($urandom_range(0, 9) < 6);
      r = $urandom_range(0, 9);
      if (r == 0) begin
        set_m(3, 0);
      end else if (r == 1) begin
        ms = NS'($urandom);
        ma = NA'($urandom);
        mc = NC'($urandom);
      end else begin
        int ty;
        ty = $urandom_range(0, 2);
        set_m(ty, $urandom_range(0, (ty == 0) ? NS - 1 : NA - 1));
      end
      for (int i = 0; i < NS; i++) rd_s[i] = $urandom;
      for (int i = 0; i < NA; i++) rd_a[i] = $urandom;
      for (int i = 0; i < NC; i++) rd_c[i] = $urandom;
      tick();
    end
    idle();
    rsp_ready = 1'b1;
    for (int t = 0; t < 8; t++) tick();
    chk("rand_drained", 32'(outstanding), 32'd0);

    // Reset with three reads in flight.
    load_banks();
    rsp_ready = 1'b0;
    rd(0, 1);
    tick();
    rd(1, 1);
    tick();
    rd(2, 3);
    tick();
    idle();
    chk("mid_valid_pre", 32'(rsp_valid), 32'd1);
    chk("mid_out_pre", 32'(outstanding), 32'd3);
    #2 rstn = 1'b0;
    #1;
    chk("mid_rst_valid", 32'(rsp_valid), 32'd0);
    chk("mid_rst_out", 32'(outstanding), 32'd0);
    chk("mid_rst_ready", 32'(req_ready), 32'd1);
    fl.delete();
    mq.delete();
    @(posedge clk);
    #1;
    k++;
    #2 rstn = 1'b1;
    @(posedge clk);
    #1;
    k++;
    rsp_ready = 1'b1;
    for (int t = 0; t < 6; t++) tick();
    chk("post_rst_none", 32'(rsp_valid), 32'd0);
    rd(1, 2);
    tick();
    idle();
    tick();
    tick();
    chk("post_rst_valid", 32'(rsp_valid), 32'd1);
    chk("post_rst_data", rsp_data, 32'hDEADBEEF);
    for (int t = 0; t < 3; t++) tick();

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
